// File: rtl/fp_bf16_pkg.sv
// rtl/fp_bf16_pkg.sv - shared bfloat16 constants, FSM states and operand classes
package fp_bf16_pkg;

  localparam int MANT_W = 7;
  localparam int EXP_W  = 8;
  localparam int BIAS   = 127;
  localparam logic [15:0]      QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_t;

  // Subnormals have no hidden bit in this unit and are folded into ZERO.
  function automatic fp_class_t classify(input logic [15:0] x);
    fp_class_t c;
    if (x[14:7] == 8'h00)
      c = ZERO;
    else if (x[14:7] == EXP_MAX)
      c = (x[6:0] != 7'h00) ? NAN : INF;
    else
      c = NORMAL;
    return c;
  endfunction

  function automatic fp_class_t combine(input fp_class_t a, input fp_class_t b);
    fp_class_t c;
    if (a == NAN || b == NAN || (a == ZERO && b == INF) || (a == INF && b == ZERO))
      c = NAN;
    else if (a == INF || b == INF)
      c = INF;
    else if (a == ZERO || b == ZERO)
      c = ZERO;
    else
      c = NORMAL;
    return c;
  endfunction

endpackage

// File: rtl/fp_bf16_round.sv
// rtl/fp_bf16_round.sv - normalize, round-to-nearest-even and special override of a raw product
module fp_bf16_round
  import fp_bf16_pkg::*;
(
  input  logic               s,
  input  logic signed [9:0]  e,
  input  logic [15:0]        p,
  input  fp_class_t          cls,
  output logic [15:0]        y
);

  logic              hi;
  logic [6:0]        frac;
  logic              g, r, st, inc;
  logic [7:0]        frac_rnd;
  logic signed [9:0] e_rnd;

  always_comb begin
    hi   = p[15];
    frac = 7'h00;
    g    = 1'b0;
    r    = 1'b0;
    st   = 1'b0;
    if (hi) begin
      frac = p[14:8];
      g    = p[7];
      r    = p[6];
      st   = |p[5:0];
    end else begin
      frac = p[13:7];
      g    = p[6];
      r    = p[5];
      st   = |p[4:0];
    end
    inc      = g & (r | st | frac[0]);
    frac_rnd = {1'b0, frac} + {7'h00, inc};
    // A carry out of the fraction leaves frac_rnd[6:0] at zero, so only the exponent moves.
    e_rnd    = e + $signed({9'h000, hi}) + $signed({9'h000, frac_rnd[7]});

    y = {s, 15'h0000};
    case (cls)
      NAN:    y = QNAN;
      INF:    y = {s, EXP_MAX, 7'h00};
      ZERO:   y = {s, 15'h0000};
      default: begin
        if (e_rnd >= 10'sd255)
          y = {s, EXP_MAX, 7'h00};
        else if (e_rnd <= 10'sd0)
          y = {s, 15'h0000};
        else
          y = {s, e_rnd[7:0], frac_rnd[6:0]};
      end
    endcase
  end

endmodule

// File: rtl/fpmul_seq.sv
// rtl/fpmul_seq.sv - iterative bfloat16 multiplier, one multiplier bit per cycle, fixed latency
module fpmul_seq
  import fp_bf16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  output logic [15:0] y,
  output logic        ready
);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic [15:0]       acc;
  logic [7:0]        ma, mb;
  logic              sgn;
  logic signed [9:0] exp_r;
  fp_class_t         cls;

  logic              capture, mul_step, load_y;
  logic [15:0]       partial;
  logic [15:0]       y_nxt;
  logic [9:0]        e_sum;

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = MUL;
      MUL:     if (cnt == 4'd7) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture  = (state == IDLE) && en;
    mul_step = (state == MUL);
    load_y   = (state == NORM);
  end

  // Exponent may go negative or past 255 here; the rounder resolves both.
  assign e_sum   = {2'b00, x1[14:7]} + {2'b00, x2[14:7]} - 10'(BIAS);
  assign partial = mb[cnt[2:0]] ? ({8'h00, ma} << cnt[2:0]) : 16'h0000;

  fp_bf16_round u_round (
    .s   (sgn),
    .e   (exp_r),
    .p   (acc),
    .cls (cls),
    .y   (y_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= 4'd0;
      acc   <= 16'h0000;
      ma    <= 8'h00;
      mb    <= 8'h00;
      sgn   <= 1'b0;
      exp_r <= 10'sd0;
      cls   <= ZERO;
      y     <= 16'h0000;
      ready <= 1'b0;
    end else begin
      ready <= load_y;
      if (capture) begin
        ma    <= {1'b1, x1[6:0]};
        mb    <= {1'b1, x2[6:0]};
        sgn   <= x1[15] ^ x2[15];
        exp_r <= e_sum;
        cls   <= combine(classify(x1), classify(x2));
        acc   <= 16'h0000;
        cnt   <= 4'd0;
      end
      if (mul_step) begin
        acc <= acc + partial;
        cnt <= cnt + 4'd1;
      end
      if (load_y)
        y <= y_nxt;
    end
  end

endmodule

// File: tb/tb_fpmul_seq.sv
// tb/tb_fpmul_seq.sv - table-driven scoreboard bench for fpmul_seq
module tb_fpmul_seq;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  localparam int NVEC = 22;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] x1 = 16'h0000;
  logic [15:0] x2 = 16'h0000;
  logic [15:0] y;
  logic        ready;

  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;
  int          cyc = 0;
  int          last_ready_cyc = 0;
  logic        prev_ready = 1'b0;
  logic [15:0] exp_q[$];
  vec_t        tbl[NVEC];

  always #5 clk = ~clk;

  fpmul_seq dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .x1    (x1),
    .x2    (x2),
    .y     (y),
    .ready (ready)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Every wait goes through here, so every ready pulse is scored exactly once.
  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    cyc++;
    if (ready) begin
      pulses++;
      last_ready_cyc = cyc;
      check_int("ready_one_cycle", int'(prev_ready), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready actual=%h expected=none", y);
      end else begin
        e = exp_q.pop_front();
        check("result", y, e);
      end
    end
    prev_ready = ready;
  endtask

  task automatic wait_ready(input int budget);
    int start;
    int n;
    start = pulses;
    n = 0;
    while (pulses == start && n < budget) begin
      tick();
      n++;
    end
    if (pulses == start) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=no_pulse expected=pulse within %0d cycles", budget);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    x1 = a;
    x2 = b;
    en = 1'b1;
    exp_q.push_back(exp);
    tick();
    en = 1'b0;
    x1 = 16'($urandom);
    x2 = 16'($urandom);
    wait_ready(30);
    tick();
  endtask

  initial begin
    int c0;
    int c1;
    int p0;

    tbl[0]  = '{16'hBFC0, 16'h4020, 16'hC070};
    tbl[1]  = '{16'h3FC0, 16'hC020, 16'hC070};
    tbl[2]  = '{16'hBFC0, 16'hC020, 16'h4070};
    tbl[3]  = '{16'h3F81, 16'h3F81, 16'h3F82};
    tbl[4]  = '{16'h3F83, 16'h3F80, 16'h3F83};
    tbl[5]  = '{16'h7F00, 16'h7F00, 16'h7F80};
    tbl[6]  = '{16'h0080, 16'h0080, 16'h0000};
    tbl[7]  = '{16'h8080, 16'h0080, 16'h8000};
    tbl[8]  = '{16'h0000, 16'h7F80, 16'h7FC0};
    tbl[9]  = '{16'h7FC1, 16'h3F80, 16'h7FC0};
    tbl[10] = '{16'h7F80, 16'hC000, 16'hFF80};
    tbl[11] = '{16'h0001, 16'h4000, 16'h0000};
    tbl[12] = '{16'h3F81, 16'h3FC0, 16'h3FC2};
    tbl[13] = '{16'h3F83, 16'h3FC0, 16'h3FC4};
    tbl[14] = '{16'h3FA8, 16'h3FC3, 16'h4000};
    tbl[15] = '{16'h0080, 16'h3F80, 16'h0080};
    tbl[16] = '{16'h0080, 16'h3F00, 16'h0000};
    tbl[17] = '{16'h7F00, 16'h3F80, 16'h7F00};
    tbl[18] = '{16'h7F00, 16'h4000, 16'h7F80};
    tbl[19] = '{16'hFF80, 16'h8000, 16'h7FC0};
    tbl[20] = '{16'h8000, 16'hC000, 16'h0000};
    tbl[21] = '{16'h4040, 16'h4000, 16'h40C0};

    rst = 1'b0;
    repeat (10) tick();
    check("reset_y", y, 16'h0000);
    check_int("reset_ready", int'(ready), 0);
    rst = 1'b1;
    tick();

    // Back-to-back with en held high: latency and throughput.
    x1 = 16'h4040;
    x2 = 16'h4000;
    en = 1'b1;
    exp_q.push_back(16'h40C0);
    exp_q.push_back(16'h40C0);
    c0 = cyc;
    wait_ready(30);
    check_int("first_latency", last_ready_cyc - c0, 10);
    c1 = last_ready_cyc;
    wait_ready(30);
    check_int("result_interval", last_ready_cyc - c1, 11);
    en = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].exp);

    p0 = pulses;
    repeat (5) tick();
    check("idle_hold_y", y, tbl[NVEC-1].exp);
    check_int("idle_no_pulse", pulses, p0);

    // Abort: reset lands on the 4th MUL edge.
    x1 = 16'h4040;
    x2 = 16'h4000;
    en = 1'b1;
    tick();
    en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    p0 = pulses;
    repeat (20) tick();
    check_int("abort_no_pulse", pulses, p0);
    check("abort_y", y, 16'h0000);

    run_op(16'h4000, 16'h4000, 16'h4080);

    check_int("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
